// File: rtl/sync_fifo_pkg.sv
// Shared FIFO definitions: default geometry and the clog2 helper used to
// size pointers and occupancy counters in this and later FIFO blocks.
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 8;

    // Smallest number of bits able to index 'value' distinct items.
    function automatic int fifo_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) ();

    localparam int CW = fifo_clog2(DEPTH + 1);

    logic             flush;
    logic             w_en;
    logic [WIDTH-1:0] w_data;
    logic             r_en;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             full;
    logic             r_empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, w_en, w_data, r_en,
        input  r_data, r_valid, full, r_empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, w_en, w_data, r_en,
        output r_data, r_valid, full, r_empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage with one write port and one registered read port.
// The array itself is never reset; only the output register is.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = fifo_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    // Store the accepted word; no reset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    // Registered read; a same-address write returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem_reg[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer, occupancy, status flags and sticky error
// flags around a fifo_mem storage block. Read data is registered, one
// clock after an accepted read, with no fall-through.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    sync_fifo_if.slave bus
);

    localparam int AW = fifo_clog2(DEPTH);
    localparam int CW = fifo_clog2(DEPTH + 1);

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             r_valid_reg;
    logic             overflow_reg;
    logic             underflow_reg;
    logic             full_flag;
    logic             empty_flag;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] rdata;

    // Flags come straight from the registered count, so they never glitch.
    assign full_flag  = (count_reg == CW'(DEPTH));
    assign empty_flag = (count_reg == '0);

    // A full FIFO can still take a write when a read frees the head slot.
    assign rd_acc = bus.r_en & ~bus.flush & ~empty_flag;
    assign wr_acc = bus.w_en & ~bus.flush & (~full_flag | rd_acc);

    // Pointers, occupancy, read-valid pulse and sticky errors; flush wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            r_valid_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            r_valid_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            r_valid_reg <= rd_acc;
            if (bus.w_en && !wr_acc) begin
                overflow_reg <= 1'b1;
            end
            if (bus.r_en && empty_flag) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wr_ptr_reg),
        .wdata (bus.w_data),
        .re    (rd_acc),
        .raddr (rd_ptr_reg),
        .rdata (rdata)
    );

    assign bus.r_data       = rdata;
    assign bus.r_valid      = r_valid_reg;
    assign bus.count        = count_reg;
    assign bus.full         = full_flag;
    assign bus.r_empty      = empty_flag;
    assign bus.almost_full  = (count_reg >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_reg <= CW'(AE_LEVEL));
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed bench for sync_fifo against a queue-based model.
module tb_sync_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sync_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_rdata;
    bit               m_rvalid;
    bit               m_ovf;
    bit               m_udf;

    int n_checks = 0;
    int n_fail   = 0;
    int txn      = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s txn=%0d actual=%0h expected=%0h", tag, txn, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rdata  = '0;
        m_rvalid = 1'b0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
    endtask

    task automatic compare_all();
        int sz;
        sz = q.size();
        check_val("count",        32'(bus.count),        32'(sz));
        check_val("full",         32'(bus.full),         32'(sz == DEPTH));
        check_val("r_empty",      32'(bus.r_empty),      32'(sz == 0));
        check_val("almost_full",  32'(bus.almost_full),  32'(sz >= AF));
        check_val("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE));
        check_val("overflow",     32'(bus.overflow),     32'(m_ovf));
        check_val("underflow",    32'(bus.underflow),    32'(m_udf));
        check_val("r_valid",      32'(bus.r_valid),      32'(m_rvalid));
        check_val("r_data",       32'(bus.r_data),       32'(m_rdata));
    endtask

    // One clock: drive, advance the model at the edge, then compare.
    task automatic cycle(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit f);
        int  sz;
        bit  rd;
        bit  wr;
        bus.w_en   = w;
        bus.w_data = d;
        bus.r_en   = r;
        bus.flush  = f;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (f) begin
            q.delete();
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
            m_rvalid = 1'b0;
        end else begin
            sz = q.size();
            rd = r && (sz > 0);
            wr = w && ((sz < DEPTH) || rd);
            if (r && sz == 0) m_udf = 1'b1;
            if (w && !wr)     m_ovf = 1'b1;
            m_rvalid = rd;
            if (rd) m_rdata = q.pop_front();
            if (wr) q.push_back(d);
        end
        #1;
        txn++;
        $display("txn %0d w=%0b d=%02h r=%0b f=%0b count=%0d r_valid=%0b r_data=%02h",
                 txn, w, d, r, f, bus.count, bus.r_valid, bus.r_data);
        compare_all();
    endtask

    initial begin
        bus.w_en   = 1'b0;
        bus.w_data = '0;
        bus.r_en   = 1'b0;
        bus.flush  = 1'b0;
        model_reset();

        // Power-on reset
        #2 rst_n = 1'b0;
        #1 compare_all();
        cycle(1'b1, 8'h99, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        #3 rst_n = 1'b1;

        // Fill to full, then an overflowing write
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);

        // Drain back-to-back, then an underflowing read
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous read and write while full
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Pointer wrap with occupancy held at or below 3
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i), (i >= 3), 1'b0);
        for (int i = 0; i < 3; i++)  cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush beats simultaneous write and read at count 5 with overflow set
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'hBB, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset between edges at count 4
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("async_count",   32'(bus.count),   32'd0);
        check_val("async_r_empty", 32'(bus.r_empty), 32'd1);
        check_val("async_r_valid", 32'(bus.r_valid), 32'd0);
        #2 rst_n = 1'b1;
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_val("post_reset_data", 32'(bus.r_data), 32'h5A);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data bits per entry (>=1).
REQ-002 Parameter DEPTH, default 8, entry count (power of two, >=2).
REQ-003 Parameter AF_LEVEL, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 Parameter AE_LEVEL, default 2, count at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 flush  input  1  synchronous clear of contents and error flags.
REQ-008 w_en  input  1  write request.
REQ-009 w_data  input  WIDTH  write data, sampled with w_en.
REQ-010 r_en  input  1  read request.
REQ-011 r_data  output  WIDTH  registered read data.
REQ-012 r_valid  output  1  one-cycle pulse, r_data holds the word popped on the previous edge.
REQ-013 full, r_empty, almost_full, almost_empty  output  1 each  status flags derived from count.
REQ-014 count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write accepted = w_en & ~flush & (~full | read accepted in the same cycle); accepted word stored at write pointer, pointer +1.
REQ-017 Read accepted = r_en & ~flush & ~r_empty; head word loaded into r_data on the same edge, read pointer +1, r_valid=1 for the following cycle.
REQ-018 Read latency is exactly one clock from accepted r_en to r_valid; no first-word fall-through.
REQ-019 r_valid is 0 in every cycle not following an accepted read; r_data holds its last value otherwise.
REQ-020 Pointers are log2(DEPTH) bits and wrap modulo DEPTH with no extra logic.
REQ-021 count +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write.
REQ-022 full = (count==DEPTH); r_empty = (count==0); almost_full = (count>=AF_LEVEL); almost_empty = (count<=AE_LEVEL); all derive from registered count, so they are glitch-free.
REQ-023 Full with w_en and r_en: both accepted, count stays DEPTH.
REQ-024 Empty with w_en and r_en: write accepted, read rejected, underflow set, count becomes 1.
REQ-025 w_en while full with no accepted read: data dropped, contents unchanged, overflow set.
REQ-026 r_en while empty: no pop, r_valid stays 0, underflow set.
REQ-027 overflow and underflow remain 1 until flush or reset.
REQ-028 flush has priority over w_en and r_en: pointers and count go to 0 and overflow, underflow and r_valid go to 0 on the next edge; r_data is unchanged; stored words are not cleared.

Reset
REQ-029 rst_n low asynchronously clears pointers, count, r_data, r_valid, overflow and underflow to 0.
REQ-030 During reset and after it, outputs read r_empty=1, almost_empty=1, full=0, almost_full=0 (for AF_LEVEL>0).
REQ-031 Memory array has no reset; content is unspecified until written.
REQ-032 Reset asserted mid-operation discards all contents; the first read after release requires a new write.

Structure
REQ-033 Shared package fifo_pkg holds the clog2 helper and the default WIDTH/DEPTH constants reused by later FIFO blocks.
REQ-034 One sub-module fifo_mem: DEPTH x WIDTH register array with one write port (we, waddr, wdata) and one synchronous read port (re, raddr, rdata); pointer, count and flag logic stay in sync_fifo.

Verification
REQ-035 Reset then write 0x11..0x18 (8 writes) -> full=1, count=8, almost_full set from count=6; a 9th write of 0xFF -> overflow=1, contents unchanged.
REQ-036 Read 8 times back-to-back -> r_valid each cycle after r_en with r_data 0x11..0x18 in order, then r_empty=1; a 9th r_en -> underflow=1, r_valid=0.
REQ-037 At count=8, assert w_en(0xAA) and r_en together -> r_data=oldest word, count stays 8, no overflow; drain and check 0xAA arrives last.
REQ-038 Wrap: 20 write/read pairs of 0x00..0x13 with count oscillating 0..3 -> output order exact across pointer wrap, count never exceeds 3.
REQ-039 At count=5 with overflow=1, flush with w_en and r_en high -> count=0, r_empty=1, overflow=0, r_valid=0, no write stored.
REQ-040 Drop rst_n asynchronously between clock edges at count=4 -> count=0, r_empty=1 immediately; first post-reset write/read returns the new value.
